// File: rtl/rr_distributor_if.sv
// Handshake bundle for rr_distributor: one upstream valid/ready stream plus
// NUM_OUT downstream valid/ready lanes sharing a single payload bus.
interface rr_distributor_if #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IdxW = $clog2(NUM_OUT);

    logic                  flush_i;
    logic [NUM_OUT-1:0]    mask_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic [NUM_OUT-1:0]    valid_o;
    logic [NUM_OUT-1:0]    ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic [IdxW-1:0]       idx_o;

    modport master (
        output flush_i, mask_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, idx_o
    );

    modport slave (
        input  flush_i, mask_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, idx_o
    );
endinterface

// File: rtl/rr_distributor.sv
// Round-robin distributor: each accepted input beat is locked into a one-entry
// output register aimed at one enabled output, chosen by a rotating pointer.
module rr_distributor #(
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rr_distributor_if.slave  bus
);
    localparam int IdxW = $clog2(NUM_OUT);

    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic [IdxW-1:0]       tgt_p0;
    logic [IdxW-1:0]       ptr_q;

    logic [IdxW-1:0]       sel;
    logic [IdxW-1:0]       ptr_nxt;
    logic [IdxW:0]         cand;
    logic                  found;
    logic                  any;
    logic                  drain;
    logic                  load;

    // Scan from the pointer, wrapping at NUM_OUT-1 so non-power-of-2 counts work.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            cand = {1'b0, ptr_q} + (IdxW+1)'(j);
            if (cand >= (IdxW+1)'(NUM_OUT)) begin
                cand = cand - (IdxW+1)'(NUM_OUT);
            end
            if (!found && bus.mask_i[cand[IdxW-1:0]]) begin
                sel   = cand[IdxW-1:0];
                found = 1'b1;
            end
        end
    end

    assign any     = |bus.mask_i;
    assign ptr_nxt = (sel == IdxW'(NUM_OUT - 1)) ? '0 : sel + IdxW'(1);
    assign drain   = vld_p0 & bus.ready_i[tgt_p0];
    assign load    = bus.valid_i & bus.ready_o;

    assign bus.ready_o = any & (~vld_p0 | drain) & ~bus.flush_i;

    // Stage p0: locked output register; target and payload only change on load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            tgt_p0  <= '0;
            ptr_q   <= '0;
        end else if (bus.flush_i) begin
            vld_p0  <= 1'b0;
            ptr_q   <= '0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            data_p0 <= bus.data_i;
            tgt_p0  <= sel;
            ptr_q   <= ptr_nxt;
        end else if (drain) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.valid_o = vld_p0 ? (NUM_OUT'(1) << tgt_p0) : '0;
    assign bus.data_o  = data_p0;
    assign bus.idx_o   = tgt_p0;
endmodule

// File: tb/tb_rr_distributor.sv
// Bench for rr_distributor: a 4-output and a 3-output instance driven by directed
// and random steps, compared each cycle against a behavioural model.
module tb_rr_distributor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_distributor_if #(.NUM_OUT(4), .DATA_WIDTH(32)) b4 ();
    rr_distributor_if #(.NUM_OUT(3), .DATA_WIDTH(32)) b3 ();

    rr_distributor #(.NUM_OUT(4), .DATA_WIDTH(32)) dut4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));
    rr_distributor #(.NUM_OUT(3), .DATA_WIDTH(32)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));

    logic        flush_v [2];
    logic [3:0]  mask_v  [2];
    logic        valid_v [2];
    logic [31:0] data_v  [2];
    logic [3:0]  rdy_v   [2];

    assign b4.flush_i = flush_v[0];
    assign b4.mask_i  = mask_v[0];
    assign b4.valid_i = valid_v[0];
    assign b4.data_i  = data_v[0];
    assign b4.ready_i = rdy_v[0];
    assign b3.flush_i = flush_v[1];
    assign b3.mask_i  = mask_v[1][2:0];
    assign b3.valid_i = valid_v[1];
    assign b3.data_i  = data_v[1];
    assign b3.ready_i = rdy_v[1][2:0];

    logic [3:0]  o_valid [2];
    logic        o_ready [2];
    logic [31:0] o_data  [2];
    logic [1:0]  o_idx   [2];

    assign o_valid[0] = b4.valid_o;
    assign o_ready[0] = b4.ready_o;
    assign o_data[0]  = b4.data_o;
    assign o_idx[0]   = b4.idx_o;
    assign o_valid[1] = {1'b0, b3.valid_o};
    assign o_ready[1] = b3.ready_o;
    assign o_data[1]  = b3.data_o;
    assign o_idx[1]   = b3.idx_o;

    // Reference state: one held beat per instance and the next-priority output.
    bit          m_full [2];
    logic [31:0] m_data [2];
    int          m_tgt  [2];
    int          m_ptr  [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
            m_tgt[i]  = 0;
            m_ptr[i]  = 0;
        end
    endtask

    task automatic model_step(input int i);
        int         n;
        int         sel;
        int         k;
        logic [3:0] m;
        logic [3:0] r;
        bit         drain;
        bit         rdy_exp;
        logic [3:0] v_exp;
        n     = (i == 0) ? 4 : 3;
        m     = (i == 0) ? mask_v[i] : (mask_v[i] & 4'h7);
        r     = (i == 0) ? rdy_v[i]  : (rdy_v[i]  & 4'h7);
        drain = m_full[i] && (((r >> m_tgt[i]) & 4'd1) != 4'd0);
        sel   = -1;
        for (int j = 0; j < n; j++) begin
            k = (m_ptr[i] + j) % n;
            if (sel < 0 && ((m >> k) & 4'd1) != 4'd0) sel = k;
        end
        rdy_exp = (m != 4'd0) && (!m_full[i] || drain) && !flush_v[i];
        v_exp   = m_full[i] ? (4'd1 << m_tgt[i]) : 4'd0;
        chk($sformatf("n%0d_valid_o", n), 32'(o_valid[i]), 32'(v_exp));
        chk($sformatf("n%0d_ready_o", n), 32'(o_ready[i]), 32'(rdy_exp));
        chk($sformatf("n%0d_data_o", n),  o_data[i], m_data[i]);
        chk($sformatf("n%0d_idx_o", n),   32'(o_idx[i]), 32'(m_tgt[i]));
        if (flush_v[i]) begin
            m_full[i] = 1'b0;
            m_ptr[i]  = 0;
        end else if (valid_v[i] && rdy_exp) begin
            m_full[i] = 1'b1;
            m_data[i] = data_v[i];
            m_tgt[i]  = sel;
            m_ptr[i]  = (sel + 1) % n;
        end else if (drain) begin
            m_full[i] = 1'b0;
        end
    endtask

    // Called just after a rising edge; checks mid-cycle, advances one clock.
    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] d,
                         input logic [3:0] m, input logic [3:0] r);
        valid_v[i] = v;
        data_v[i]  = d;
        mask_v[i]  = m;
        rdy_v[i]   = r;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush_v[i] = 1'b0;
            drive(i, 1'b0, 32'h0, 4'h0, 4'h0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid_o", 32'(o_valid[i]), 32'h0);
            chk("rst_data_o",  o_data[i],       32'h0);
            chk("rst_idx_o",   32'(o_idx[i]),   32'h0);
        end
        rst = 1'b0;
        cycle();

        // Full mask, all ready: strict rotation with one beat per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, 32'hD000_0000 + 32'(k), 4'hF, 4'hF);
            cycle();
            chk("t1_idx",   32'(o_idx[0]),   32'(k % 4));
            chk("t1_valid", 32'(o_valid[0]), 32'(4'd1 << (k % 4)));
            chk("t1_data",  o_data[0],       32'hD000_0000 + 32'(k));
            chk("t1_ready", 32'(o_ready[0]), 32'h1);
        end
        drive(0, 1'b0, 32'h0, 4'hF, 4'hF);
        cycle();

        // Sparse mask, then mask change under a locked beat.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 32'hB000_0000 + 32'(k), 4'b1010, 4'hF);
            cycle();
            chk("t2_idx", 32'(o_idx[0]), (k % 2 == 1) ? 32'd3 : 32'd1);
        end
        drive(0, 1'b0, 32'h0, 4'b0101, 4'h0);
        cycle();
        chk("t2_lock_idx",   32'(o_idx[0]),   32'd3);
        chk("t2_lock_valid", 32'(o_valid[0]), 32'h8);
        drive(0, 1'b1, 32'hB100_0000, 4'b0101, 4'hF);
        cycle();
        chk("t2_next_idx", 32'(o_idx[0]), 32'd0);
        drive(0, 1'b0, 32'h0, 4'b0101, 4'hF);
        cycle();

        // Stall on output 2, then drain and load in the same cycle.
        drive(0, 1'b1, 32'hC000_0000, 4'b0100, 4'b1011);
        cycle();
        data_v[0] = 32'hC000_0001;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_stall_valid", 32'(o_valid[0]), 32'h4);
            chk("t3_stall_data",  o_data[0],       32'hC000_0000);
            chk("t3_stall_ready", 32'(o_ready[0]), 32'h0);
        end
        rdy_v[0] = 4'hF;
        cycle();
        chk("t3_reload_valid", 32'(o_valid[0]), 32'h4);
        chk("t3_reload_data",  o_data[0],       32'hC000_0001);
        drive(0, 1'b1, 32'hC000_0002, 4'hF, 4'hF);
        cycle();
        chk("t3_ptr_idx", 32'(o_idx[0]), 32'd3);
        drive(0, 1'b0, 32'h0, 4'hF, 4'hF);
        cycle();

        // Empty mask blocks the input; enabling output 0 releases it.
        drive(0, 1'b1, 32'hA000_0000, 4'h0, 4'hF);
        cycle();
        cycle();
        chk("t4_empty_valid", 32'(o_valid[0]), 32'h0);
        chk("t4_empty_ready", 32'(o_ready[0]), 32'h0);
        mask_v[0] = 4'b0001;
        cycle();
        chk("t4_load_idx",  32'(o_idx[0]), 32'd0);
        chk("t4_load_data", o_data[0],     32'hA000_0000);
        drive(0, 1'b1, 32'hA000_0001, 4'hF, 4'hF);
        cycle();
        chk("t4_ptr_idx", 32'(o_idx[0]), 32'd1);
        drive(0, 1'b0, 32'h0, 4'hF, 4'hF);
        cycle();

        // Flush drops a held beat; an async reset pulse does the same.
        drive(0, 1'b1, 32'hF000_0000, 4'b1000, 4'h0);
        cycle();
        chk("t5_held_idx", 32'(o_idx[0]), 32'd3);
        drive(0, 1'b0, 32'h0, 4'b1000, 4'h0);
        flush_v[0] = 1'b1;
        cycle();
        flush_v[0] = 1'b0;
        chk("t5_flush_valid", 32'(o_valid[0]), 32'h0);
        drive(0, 1'b1, 32'hF000_0001, 4'hF, 4'hF);
        cycle();
        chk("t5_flush_idx", 32'(o_idx[0]), 32'd0);
        drive(0, 1'b0, 32'h0, 4'hF, 4'hF);
        cycle();
        drive(0, 1'b1, 32'hF000_0002, 4'b0010, 4'h0);
        cycle();
        drive(0, 1'b0, 32'h0, 4'b0010, 4'h0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        chk("t5_rst_valid", 32'(o_valid[0]), 32'h0);
        chk("t5_rst_data",  o_data[0],       32'h0);
        cycle();
        drive(0, 1'b1, 32'hF000_0003, 4'hF, 4'hF);
        cycle();
        chk("t5_rst_idx", 32'(o_idx[0]), 32'd0);
        drive(0, 1'b0, 32'h0, 4'hF, 4'hF);
        cycle();

        // Three outputs: pointer wraps after index 2.
        for (int k = 0; k < 6; k++) begin
            drive(1, 1'b1, 32'h3000_0000 + 32'(k), 4'h7, 4'h7);
            cycle();
            chk("t6_idx", 32'(o_idx[1]), 32'(k % 3));
        end
        drive(1, 1'b0, 32'h0, 4'h7, 4'h7);
        cycle();

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 1'($urandom_range(0, 3) != 0), $urandom,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                flush_v[i] = ($urandom_range(0, 19) == 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
